// File: rtl/lsu_dmem_ctrl_pkg.sv
// Shared types for the load/store unit and its data-memory controller.
// Access sizes, controller states and default widths.
package lsu_dmem_ctrl_pkg;

    localparam int LSU_TAG_W     = 4;
    localparam int LSU_SIZE_POW2 = 20;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_X = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } lsu_state_t;

    // True for an illegal size or an offset the size cannot sit on.
    function automatic logic size_fault(mem_size_t size, logic [1:0] lo);
        logic f;
        f = 1'b0;
        unique case (size)
            MEM_B:   f = 1'b0;
            MEM_H:   f = lo[0];
            MEM_W:   f = |lo;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_align.sv
// Byte-lane steering for the load/store controller.
// Extracts and extends load data and merges sub-word store data.
module lsu_lane_align
    import lsu_dmem_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [4:0]  sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] mask;

    always_comb begin
        sh        = {addr_lo_i, 3'b000};
        byte_v    = rd_word_i[sh +: 8];
        half_v    = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
        ld_data_o = rd_word_i;
        mask      = '1;
        unique case (size_i)
            MEM_B: begin
                ld_data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
                mask      = 32'h0000_00FF << sh;
            end
            MEM_H: begin
                ld_data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
                mask      = 32'h0000_FFFF << sh;
            end
            default: begin
                ld_data_o = rd_word_i;
                mask      = '1;
            end
        endcase
        st_word_o = (rd_word_i & ~mask) | ((st_data_i << sh) & mask);
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller in front of a word-only data memory.
// Checks each request, drives dmem pulses and returns a tagged response.
module lsu_dmem_ctrl
    import lsu_dmem_ctrl_pkg::*;
#(
    parameter int TAG_W     = LSU_TAG_W,
    parameter int SIZE_POW2 = LSU_SIZE_POW2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_store_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_data_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_fault_o,
    output logic             dmem_read_o,
    output logic             dmem_write_o,
    output logic [31:0]      dmem_addr_o,
    output logic [31:0]      dmem_data_o,
    input  logic [31:0]      dmem_rd_data_i,
    input  logic             dmem_done_i
);

    lsu_state_t       state_q;
    logic             store_q;
    mem_size_t        size_q;
    logic             uns_q;
    logic [1:0]       lo_q;
    logic [31:0]      data_q;
    logic [TAG_W-1:0] tag_q;
    logic             fault_q;
    logic [31:0]      ld_q;

    logic             rd_q;
    logic             wr_q;
    logic [31:0]      maddr_q;
    logic [31:0]      mdata_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_fault_q;

    mem_size_t        req_size;
    logic             req_fault;
    logic [31:0]      ld_data;
    logic [31:0]      st_word;

    assign req_size    = mem_size_t'(req_size_i);
    assign req_ready_o = (state_q == IDLE);

    always_comb begin
        req_fault = size_fault(req_size, req_addr_i[1:0])
                  | (|req_addr_i[31:SIZE_POW2]);
    end

    lsu_lane_align u_align (
        .addr_lo_i  (lo_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .rd_word_i  (dmem_rd_data_i),
        .st_data_i  (data_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            size_q      <= MEM_B;
            uns_q       <= 1'b0;
            lo_q        <= 2'b00;
            data_q      <= '0;
            tag_q       <= '0;
            fault_q     <= 1'b0;
            ld_q        <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            maddr_q     <= '0;
            mdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_fault_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        store_q <= req_store_i;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned_i;
                        lo_q    <= req_addr_i[1:0];
                        data_q  <= req_data_i;
                        tag_q   <= req_tag_i;
                        fault_q <= req_fault;
                        ld_q    <= '0;
                        if (req_fault) begin
                            state_q <= RSP;
                        end else if (req_store_i && req_size == MEM_W) begin
                            state_q <= WR;
                            wr_q    <= 1'b1;
                            maddr_q <= {req_addr_i[31:2], 2'b00};
                            mdata_q <= req_data_i;
                        end else begin
                            state_q <= RD;
                            rd_q    <= 1'b1;
                            maddr_q <= {req_addr_i[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    if (dmem_done_i) begin
                        if (store_q) begin
                            // read-modify-write: push the merged word back
                            state_q <= WR;
                            wr_q    <= 1'b1;
                            mdata_q <= st_word;
                        end else begin
                            state_q <= RSP;
                            ld_q    <= ld_data;
                        end
                    end
                end
                WR: begin
                    if (dmem_done_i) begin
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= ld_q;
                    rsp_tag_q   <= tag_q;
                    rsp_fault_q <= fault_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_read_o  = rd_q;
    assign dmem_write_o = wr_q;
    assign dmem_addr_o  = maddr_q;
    assign dmem_data_o  = mdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_fault_o  = rsp_fault_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl with a word memory of latency 1 and 3.
// A request-level model predicts every response, pulse and latency.
module tb_lsu_dmem_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_store_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_tag_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [3:0]  rsp_tag_o;
    logic        rsp_fault_o;
    logic        dmem_read_o;
    logic        dmem_write_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_data_o;
    logic [31:0] dmem_rd_data_i;
    logic        dmem_done_i;

    always #5 clk_i = ~clk_i;

    lsu_dmem_ctrl #(.TAG_W(4), .SIZE_POW2(20)) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_store_i    (req_store_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_tag_i      (req_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_tag_o      (rsp_tag_o),
        .rsp_fault_o    (rsp_fault_o),
        .dmem_read_o    (dmem_read_o),
        .dmem_write_o   (dmem_write_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_data_o    (dmem_data_o),
        .dmem_rd_data_i (dmem_rd_data_i),
        .dmem_done_i    (dmem_done_i)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
        logic [3:0]  tag;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          acc;
    } exp_t;

    int ntests = 0;
    int nfail  = 0;
    int edges  = 0;
    int dlat   = 1;
    int pend   = 0;
    int cur_rd = 0;
    int cur_wr = 0;
    int rsp_count = 0;
    logic [31:0] hold;
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t exp_q[$];
    exp_t cur;
    exp_t nxt;
    logic [31:0] last_data;
    logic        last_fault;
    logic [3:0]  last_tag;
    int          last_lat;
    int          last_rd;
    int          last_wr;
    logic        acc_rsp;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Request-level prediction; updates the reference memory for stores.
    function automatic exp_t predict(bit st, logic [1:0] sz, bit un,
                                     logic [31:0] a, logic [31:0] d,
                                     logic [3:0] tg);
        exp_t e;
        int k;
        logic [31:0] w;
        logic [31:0] part;
        e.tag = tg; e.data = 0; e.rd = 0; e.wr = 0; e.acc = 0;
        e.waddr = a & 32'hFFFF_FFFC; e.wdata = 0;
        e.fault = (sz == 2'd3) || (sz == 2'd1 && a[0])
               || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'h0010_0000);
        e.lat = 1;
        if (e.fault) return e;
        w = ref_mem[a[11:2]];
        k = int'(a[1:0]);
        if (!st) begin
            e.rd = 1;
            e.lat = dlat + 2;
            if (sz == 2'd0) begin
                part = (w >> (8 * k)) & 32'hFF;
                e.data = (un || part < 128) ? part : part + 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                part = (w >> (16 * (k / 2))) & 32'hFFFF;
                e.data = (un || part < 32768) ? part : part + 32'hFFFF_0000;
            end else begin
                e.data = w;
            end
        end else begin
            e.wr = 1;
            if (sz == 2'd2) begin
                e.wdata = d;
                e.lat = dlat + 2;
            end else begin
                e.rd = 1;
                e.lat = 2 * dlat + 3;
                if (sz == 2'd0) begin
                    part = (w >> (8 * k)) & 32'hFF;
                    e.wdata = w - (part << (8 * k)) + ((d & 32'hFF) << (8 * k));
                end else begin
                    part = (w >> (16 * (k / 2))) & 32'hFFFF;
                    e.wdata = w - (part << (16 * (k / 2)))
                            + ((d & 32'hFFFF) << (16 * (k / 2)));
                end
            end
            ref_mem[a[11:2]] = e.wdata;
        end
        return e;
    endfunction

    always @(posedge clk_i) edges++;

    // Word memory: done rises dlat cycles after the pulse cycle.
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            pend = 0;
            dmem_done_i = 1'b0;
        end else begin
            dmem_done_i = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dmem_done_i = 1'b1;
                    dmem_rd_data_i = hold;
                end
            end
            if (dmem_read_o) begin
                hold = mem[dmem_addr_o[11:2]];
                pend = dlat;
            end
            if (dmem_write_o) begin
                mem[dmem_addr_o[11:2]] = dmem_data_o;
                pend = dlat;
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni) begin
            if (rsp_valid_o) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("rsp_data", rsp_data_o, cur.data);
                    chk("rsp_fault", 32'(rsp_fault_o), 32'(cur.fault));
                    chk("rsp_tag", 32'(rsp_tag_o), 32'(cur.tag));
                    chk("rsp_lat", edges - cur.acc, cur.lat);
                    chk("rd_pulses", cur_rd, cur.rd);
                    chk("wr_pulses", cur_wr, cur.wr);
                    last_data = rsp_data_o; last_fault = rsp_fault_o;
                    last_tag = rsp_tag_o; last_lat = edges - cur.acc;
                    last_rd = cur_rd; last_wr = cur_wr;
                end
            end
            chk("ready", 32'(req_ready_o), 32'(exp_q.size() == 0));
            if (dmem_read_o) begin
                cur_rd++;
                if (exp_q.size() > 0) chk("rd_addr", dmem_addr_o, exp_q[0].waddr);
                else chk("rd_spurious", 32'(dmem_read_o), 32'd0);
            end
            if (dmem_write_o) begin
                cur_wr++;
                if (exp_q.size() > 0) begin
                    chk("wr_addr", dmem_addr_o, exp_q[0].waddr);
                    chk("wr_data", dmem_data_o, exp_q[0].wdata);
                end else begin
                    chk("wr_spurious", 32'(dmem_write_o), 32'd0);
                end
            end
            if (req_valid_i && req_ready_o) begin
                nxt = predict(req_store_i, req_size_i, req_unsigned_i,
                              req_addr_i, req_data_i, req_tag_i);
                nxt.acc = edges + 1;
                exp_q.push_back(nxt);
                cur_rd = 0;
                cur_wr = 0;
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
        ref_mem[a[11:2]] = w;
    endtask

    task automatic issue(input bit st, input logic [1:0] sz, input bit un,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] tg, input bit keep);
        bit ok;
        ok = 1'b0;
        req_store_i = st; req_size_i = sz; req_unsigned_i = un;
        req_addr_i = a; req_data_i = d; req_tag_i = tg;
        req_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                acc_rsp = rsp_valid_o;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk_i); #1;
        if (!keep) req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i); #1;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic suite();
        preload(32'h100, 32'h8899AABB);
        issue(0, 2'd2, 0, 32'h100, 0, 4'h3, 0); drain();
        chk("lw_data", last_data, 32'h8899AABB);
        chk("lw_tag", 32'(last_tag), 32'h3);
        chk("lw_lat", last_lat, dlat + 2);

        preload(32'h100, 32'h80112233);
        issue(0, 2'd0, 0, 32'h103, 0, 4'h4, 0); drain();
        chk("lb_data", last_data, 32'hFFFFFF80);
        issue(0, 2'd0, 1, 32'h103, 0, 4'h5, 0); drain();
        chk("lbu_data", last_data, 32'h00000080);
        issue(0, 2'd1, 1, 32'h102, 0, 4'h6, 0); drain();
        chk("lhu_data", last_data, 32'h00008011);
        issue(0, 2'd1, 0, 32'h102, 0, 4'h7, 0); drain();
        chk("lh_data", last_data, 32'hFFFF8011);

        preload(32'h100, 32'h11223344);
        issue(1, 2'd0, 0, 32'h101, 32'h000000EE, 4'h8, 0); drain();
        chk("sb_mem", mem[64], 32'h1122EE44);
        chk("sb_rd", last_rd, 1);
        chk("sb_wr", last_wr, 1);
        chk("sb_lat", last_lat, 2 * dlat + 3);
        chk("sb_data", last_data, 32'h0);
        issue(1, 2'd1, 0, 32'h102, 32'h0000BEEF, 4'h9, 0); drain();
        chk("sh_mem", mem[64], 32'hBEEFEE44);
        issue(1, 2'd2, 0, 32'h104, 32'h12345678, 4'hA, 0); drain();
        chk("sw_rd", last_rd, 0);
        chk("sw_lat", last_lat, dlat + 2);
        issue(0, 2'd2, 0, 32'h104, 0, 4'hB, 0); drain();
        chk("lw_after_sw", last_data, 32'h12345678);

        issue(0, 2'd2, 0, 32'h102, 0, 4'hC, 0); drain();
        chk("lw_mis_fault", 32'(last_fault), 32'd1);
        chk("lw_mis_lat", last_lat, 1);
        chk("lw_mis_rd", last_rd, 0);
        issue(1, 2'd1, 0, 32'h001, 32'h55, 4'hD, 0); drain();
        chk("sh_mis_fault", 32'(last_fault), 32'd1);
        chk("sh_mis_wr", last_wr, 0);
        issue(0, 2'd0, 0, 32'h0010_0000, 0, 4'hE, 0); drain();
        chk("range_fault", 32'(last_fault), 32'd1);
        issue(0, 2'd3, 0, 32'h100, 0, 4'hF, 0); drain();
        chk("size3_fault", 32'(last_fault), 32'd1);

        issue(0, 2'd2, 0, 32'h104, 0, 4'h1, 1);
        issue(0, 2'd0, 1, 32'h100, 0, 4'h2, 0);
        chk("b2b_accept_on_rsp", 32'(acc_rsp), 32'd1);
        drain();
        chk("b2b_data", last_data, 32'h00000044);
        chk("b2b_tag", 32'(last_tag), 32'h2);
    endtask

    initial begin
        int rc;
        foreach (mem[i]) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset_ni = 1'b0;
        req_valid_i = 1'b0; req_store_i = 1'b0; req_size_i = '0;
        req_unsigned_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        req_tag_i = '0; dmem_rd_data_i = '0; dmem_done_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rd", 32'(dmem_read_o), 32'd0);
        chk("rst_wr", 32'(dmem_write_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        @(posedge clk_i); #1;
        reset_ni = 1'b1;

        for (int p = 0; p < 2; p++) begin
            dlat = (p == 0) ? 1 : 3;
            suite();
        end

        dlat = 3;
        preload(32'h100, 32'hCAFEF00D);
        issue(0, 2'd2, 0, 32'h100, 0, 4'h7, 0);
        @(posedge clk_i); #1;
        reset_ni = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_rsp", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_rd", 32'(dmem_read_o), 32'd0);
        chk("mid_rst_tag", 32'(rsp_tag_o), 32'd0);
        rc = rsp_count;
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("mid_rst_no_rsp", rsp_count, rc);
        chk("mid_rst_idle", 32'(req_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
